pipelined_adder: RTL and testbench

Parametrised, pipelined successor to the combinational N-bit ripple-carry adder. It splits a BITS-wide add/subtract into STAGES equal segments, with one segment per pipeline stage and the carry registered between stages. A valid/ready handshake on both sides lets it sit between the ALU operand registers and the result bus, and accept one operation per cycle when it is not stalled. It adds subtract mode and a signed-overflow flag.

---
 rtl/pipelined_adder_pkg.sv | 7 +
 rtl/pipelined_adder_stage.sv | 70 +++++++
 rtl/ripple_carry_adder.sv | 26 ++
 rtl/pipelined_adder.sv | 83 ++++++++
 tb/tb_pipelined_adder.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared constants for the pipelined adder.
package pipelined_adder_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/pipelined_adder_stage.sv
// One pipeline stage: adds segment IDX and registers carry, operands and partial result.
module pipelined_adder_stage #(
  parameter int unsigned BITS = 32,
  parameter int unsigned SEG  = 8,
  parameter int unsigned IDX  = 0
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            adv,
  input  logic            up_valid,
  input  logic [BITS-1:0] up_a,
  input  logic [BITS-1:0] up_b,
  input  logic            up_carry,
  input  logic [BITS-1:0] up_res,
  output logic            dn_valid,
  output logic [BITS-1:0] dn_a,
  output logic [BITS-1:0] dn_b,
  output logic            dn_carry,
  output logic [BITS-1:0] dn_res
);

  logic [SEG-1:0]  seg_sum;
  logic            seg_carry;
  logic [BITS-1:0] res_d;

  logic            valid_q;
  logic [BITS-1:0] a_q;
  logic [BITS-1:0] b_q;
  logic            carry_q;
  logic [BITS-1:0] res_q;

  ripple_carry_adder #(
    .BITS(SEG)
  ) u_rca (
    .a    (up_a[IDX*SEG +: SEG]),
    .b    (up_b[IDX*SEG +: SEG]),
    .c_in (up_carry),
    .sum  (seg_sum),
    .c_out(seg_carry)
  );

  always_comb begin
    res_d                  = up_res;
    res_d[IDX*SEG +: SEG]  = seg_sum;
  end

  // Operands travel whole; later stages read only their own segment and the MSBs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
    end else if (adv) begin
      valid_q <= up_valid;
      a_q     <= up_a;
      b_q     <= up_b;
      carry_q <= seg_carry;
      res_q   <= res_d;
    end
  end

  assign dn_valid = valid_q;
  assign dn_a     = a_q;
  assign dn_b     = b_q;
  assign dn_carry = carry_q;
  assign dn_res   = res_q;

endmodule

// File: rtl/ripple_carry_adder.sv
// Combinational BITS-wide ripple-carry adder.
module ripple_carry_adder #(
  parameter int unsigned BITS = 4
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            c_in,
  output logic [BITS-1:0] sum,
  output logic            c_out
);

  logic [BITS:0] carry;

  always_comb begin
    sum      = '0;
    carry    = '0;
    carry[0] = c_in;
    for (int unsigned i = 0; i < BITS; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign c_out = carry[BITS];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract with valid/ready handshake, carry out and signed overflow.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int unsigned BITS   = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            c_in,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] sum,
  output logic            c_out,
  output logic            overflow
);

  localparam int unsigned SEG = BITS / STAGES;

  if (STAGES == 0 || (BITS % STAGES) != 0) begin : gen_bad_split
    $error("pipelined_adder: BITS must be a nonzero multiple of STAGES");
  end

  logic            adv;
  logic [BITS-1:0] b_prep;
  logic            c0;

  logic            valid_p [STAGES+1];
  logic [BITS-1:0] a_p     [STAGES+1];
  logic [BITS-1:0] b_p     [STAGES+1];
  logic            carry_p [STAGES+1];
  logic [BITS-1:0] res_p   [STAGES+1];
  logic            unused_tail;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign b_prep = (sub == MODE_SUB) ? ~b : b;
  assign c0     = (sub == MODE_SUB) ? 1'b1 : c_in;

  assign valid_p[0] = in_valid;
  assign a_p[0]     = a;
  assign b_p[0]     = b_prep;
  assign carry_p[0] = c0;
  assign res_p[0]   = '0;

  for (genvar k = 0; k < STAGES; k++) begin : gen_stage
    pipelined_adder_stage #(
      .BITS(BITS),
      .SEG (SEG),
      .IDX (k)
    ) u_stage (
      .clk     (clk),
      .clr     (clr),
      .adv     (adv),
      .up_valid(valid_p[k]),
      .up_a    (a_p[k]),
      .up_b    (b_p[k]),
      .up_carry(carry_p[k]),
      .up_res  (res_p[k]),
      .dn_valid(valid_p[k+1]),
      .dn_a    (a_p[k+1]),
      .dn_b    (b_p[k+1]),
      .dn_carry(carry_p[k+1]),
      .dn_res  (res_p[k+1])
    );
  end

  assign out_valid = valid_p[STAGES];
  assign sum       = res_p[STAGES];
  assign c_out     = carry_p[STAGES];

  // Carry into the MSB is a^b'^sum at that bit; overflow is it XOR the carry out.
  assign overflow = a_p[STAGES][BITS-1] ^ b_p[STAGES][BITS-1] ^ sum[BITS-1] ^ c_out;

  assign unused_tail = ^{a_p[STAGES], b_p[STAGES]};

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench: 32b/4-stage directed tests plus exhaustive 6b runs at 3 and 1 stages.
module tb_pipelined_adder;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int w_of [3] = '{32, 6, 6};
  int issued [3];
  int delivered [3];
  bit run_rand;

  logic [31:0] a_s [3];
  logic [31:0] b_s [3];
  logic        cin_s [3];
  logic        sub_s [3];
  logic        iv_s [3];
  logic        ordy_s [3];

  logic [31:0] sum_s [3];
  logic        ov_s [3];
  logic        ir_s [3];
  logic        cout_s [3];
  logic        ovf_s [3];

  logic [31:0] sum0;
  logic [5:0]  sum1, sum2;
  logic        ov0, ov1, ov2, ir0, ir1, ir2, co0, co1, co2, of0, of1, of2;

  pipelined_adder #(.BITS(32), .STAGES(4)) u_dut32 (
    .clk(clk), .clr(clr), .in_valid(iv_s[0]), .in_ready(ir0), .a(a_s[0]), .b(b_s[0]),
    .c_in(cin_s[0]), .sub(sub_s[0]), .out_valid(ov0), .out_ready(ordy_s[0]), .sum(sum0),
    .c_out(co0), .overflow(of0)
  );

  pipelined_adder #(.BITS(6), .STAGES(3)) u_dut6s3 (
    .clk(clk), .clr(clr), .in_valid(iv_s[1]), .in_ready(ir1), .a(a_s[1][5:0]),
    .b(b_s[1][5:0]), .c_in(cin_s[1]), .sub(sub_s[1]), .out_valid(ov1),
    .out_ready(ordy_s[1]), .sum(sum1), .c_out(co1), .overflow(of1)
  );

  pipelined_adder #(.BITS(6), .STAGES(1)) u_dut6s1 (
    .clk(clk), .clr(clr), .in_valid(iv_s[2]), .in_ready(ir2), .a(a_s[2][5:0]),
    .b(b_s[2][5:0]), .c_in(cin_s[2]), .sub(sub_s[2]), .out_valid(ov2),
    .out_ready(ordy_s[2]), .sum(sum2), .c_out(co2), .overflow(of2)
  );

  always_comb begin
    sum_s[0] = sum0;  sum_s[1] = {26'd0, sum1};  sum_s[2] = {26'd0, sum2};
    ov_s[0]  = ov0;   ov_s[1]  = ov1;            ov_s[2]  = ov2;
    ir_s[0]  = ir0;   ir_s[1]  = ir1;            ir_s[2]  = ir2;
    cout_s[0] = co0;  cout_s[1] = co1;           cout_s[2] = co2;
    ovf_s[0] = of0;   ovf_s[1] = of1;            ovf_s[2] = of2;
  end

  // Reference: {overflow, c_out, sum} from plain integer arithmetic at width w.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub, input int w);
    longint one = 1;
    longint mask, ua, ub, sa, sb, full, sres;
    logic   cout, ovf;
    logic [31:0] s;
    mask = (one << w) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = (ua >= (one << (w - 1))) ? ua - (one << w) : ua;
    sb = (ub >= (one << (w - 1))) ? ub - (one << w) : ub;
    if (sub) begin
      full = ua - ub;
      cout = (ua >= ub);
      sres = sa - sb;
    end else begin
      full = ua + ub + longint'(cin);
      cout = (full > mask);
      sres = sa + sb + longint'(cin);
    end
    ovf = (sres >= (one << (w - 1))) || (sres < -(one << (w - 1)));
    s = 32'(full & mask);
    return {ovf, cout, s};
  endfunction

  logic [33:0] exp_q0 [$], exp_q1 [$], exp_q2 [$];
  logic [34:0] lit_q0 [$], lit_q1 [$], lit_q2 [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  task automatic push_exp(input int d, input logic [33:0] e, input logic [34:0] l);
    case (d)
      0:       begin exp_q0.push_back(e); lit_q0.push_back(l); end
      1:       begin exp_q1.push_back(e); lit_q1.push_back(l); end
      default: begin exp_q2.push_back(e); lit_q2.push_back(l); end
    endcase
  endtask

  task automatic pop_exp(input int d, output bit ok, output logic [33:0] e,
                         output logic [34:0] l);
    ok = (qsize(d) != 0);
    e  = '0;
    l  = '0;
    if (ok) begin
      case (d)
        0:       begin e = exp_q0.pop_front(); l = lit_q0.pop_front(); end
        1:       begin e = exp_q1.pop_front(); l = lit_q1.pop_front(); end
        default: begin e = exp_q2.pop_front(); l = lit_q2.pop_front(); end
      endcase
    end
  endtask

  // Compare process: every output transfer and every stalled cycle.
  logic        stall_prev [3];
  logic [33:0] held [3];

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      logic [33:0] got, e;
      logic [34:0] l;
      bit ok;
      got = {ovf_s[d], cout_s[d], sum_s[d]};
      if (!clr) begin
        stall_prev[d] = 1'b0;
      end else begin
        if (stall_prev[d] && ov_s[d])
          check($sformatf("hold_stable[%0d]", d), 64'(got), 64'(held[d]));
        if (ov_s[d] && ordy_s[d]) begin
          pop_exp(d, ok, e, l);
          check($sformatf("result_expected[%0d]", d), 64'(ok), 64'd1);
          if (ok) begin
            delivered[d]++;
            check($sformatf("model[%0d]", d), 64'(got), 64'(e));
            if (l[34]) check("literal", 64'(got), 64'(l[33:0]));
          end
        end
        stall_prev[d] = ov_s[d] && !ordy_s[d];
        held[d] = got;
      end
    end
  end

  // Presents one op on DUT d and holds it until accepted; returns just after the accept edge.
  task automatic issue(input int d, input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic sub, input bit has_lit, input logic [33:0] lit);
    bit done = 1'b0;
    a_s[d] = a; b_s[d] = b; cin_s[d] = cin; sub_s[d] = sub; iv_s[d] = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (ir_s[d] && clr) begin
        push_exp(d, model(a, b, cin, sub, w_of[d]), {has_lit, lit});
        issued[d]++;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("issue_accepted", 64'(done), 64'd1);
  endtask

  task automatic wait_drain(input int d);
    for (int n = 0; n < 500 && qsize(d) != 0; n++) @(negedge clk);
    @(negedge clk);
    check($sformatf("drained[%0d]", d), 64'(qsize(d)), 64'd0);
    check($sformatf("count[%0d]", d), 64'(delivered[d]), 64'(issued[d]));
    @(posedge clk); #1;
  endtask

  task automatic exhaust(input int d);
    for (int ia = 0; ia < 64; ia++)
      for (int ib = 0; ib < 64; ib++)
        for (int m = 0; m < 4; m++) begin
          if ($urandom_range(0, 3) == 0) begin
            iv_s[d] = 1'b0;
            @(posedge clk); #1;
          end
          issue(d, 32'(ia), 32'(ib), m[0], m[1], 1'b0, '0);
        end
    iv_s[d] = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      a_s[d] = '0; b_s[d] = '0; cin_s[d] = 1'b0; sub_s[d] = 1'b0;
      iv_s[d] = 1'b0; ordy_s[d] = 1'b1; issued[d] = 0; delivered[d] = 0;
      stall_prev[d] = 1'b0; held[d] = '0;
    end

    // Reset state
    #12;
    check("rst_out_valid", 64'(ov_s[0]), 64'd0);
    check("rst_sum", 64'(sum_s[0]), 64'd0);
    check("rst_c_out", 64'(cout_s[0]), 64'd0);
    check("rst_overflow", 64'(ovf_s[0]), 64'd0);
    check("rst_in_ready", 64'(ir_s[0]), 64'd1);
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1;

    // Carry through all segments; latency exactly 4
    issue(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, {1'b0, 1'b1, 32'h0});
    iv_s[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("latency_valid[%0d]", k), 64'(ov_s[0]), (k == 3) ? 64'd1 : 64'd0);
    end
    @(posedge clk); #1;

    // Directed vectors, back to back
    issue(0, 32'd5, 32'd7, 1'b0, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
    issue(0, 32'd7, 32'd5, 1'b1, 1'b1, 1'b1, {1'b0, 1'b1, 32'h0000_0002});
    issue(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, {1'b1, 1'b0, 32'h8000_0000});
    issue(0, 32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF});
    issue(0, 32'h1, 32'h2, 1'b1, 1'b0, 1'b1, {1'b0, 1'b0, 32'h0000_0004});
    issue(0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, {1'b0, 1'b1, 32'h0000_0000});
    issue(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, {1'b1, 1'b1, 32'h0});
    issue(0, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b1, {1'b0, 1'b0, 32'h2143_6587});
    issue(0, 32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 1'b1, {1'b0, 1'b0, 32'h0100_0100});
    iv_s[0] = 1'b0;
    wait_drain(0);

    // Backpressure: six ops, 3-cycle stall once results appear
    fork
      begin
        for (int i = 0; i < 6; i++)
          issue(0, 32'(i) * 32'h1111_1111, 32'h0F0F_0F0F, 1'b0, 1'(i), 1'b0, '0);
        iv_s[0] = 1'b0;
      end
      begin
        bit seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
          @(negedge clk);
          seen = ov_s[0];
        end
        check("bp_first_valid", 64'(seen), 64'd1);
        @(posedge clk); #1;
        ordy_s[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("bp_in_ready_low", 64'(ir_s[0]), 64'd0);
          check("bp_valid_held", 64'(ov_s[0]), 64'd1);
        end
        @(posedge clk); #1;
        ordy_s[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("bp_one_per_cycle", 64'(ov_s[0]), 64'd1);
        end
      end
    join
    wait_drain(0);

    // Asynchronous reset with ops in flight
    issue(0, 32'd100, 32'd23, 1'b0, 1'b0, 1'b0, '0);
    issue(0, 32'd200, 32'd45, 1'b0, 1'b1, 1'b0, '0);
    issue(0, 32'd300, 32'd67, 1'b1, 1'b0, 1'b0, '0);
    iv_s[0] = 1'b0;
    @(posedge clk); #3;
    clr = 1'b0;
    #1;
    check("arst_out_valid", 64'(ov_s[0]), 64'd0);
    check("arst_sum", 64'(sum_s[0]), 64'd0);
    check("arst_in_ready", 64'(ir_s[0]), 64'd1);
    exp_q0.delete();
    lit_q0.delete();
    issued[0] = delivered[0];
    @(posedge clk); #2;
    clr = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("no_ghost_after_reset", 64'(ov_s[0]), 64'd0);
    end
    @(posedge clk); #1;

    // Exhaustive 6-bit sweeps with bubbles and random out_ready
    run_rand = 1'b1;
    fork
      begin
        fork
          exhaust(1);
          exhaust(2);
        join
        run_rand = 1'b0;
      end
      begin
        while (run_rand) begin
          @(posedge clk); #1;
          ordy_s[1] = ($urandom_range(0, 3) != 0);
          ordy_s[2] = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(posedge clk); #1;
    ordy_s[1] = 1'b1;
    ordy_s[2] = 1'b1;
    wait_drain(1);
    wait_drain(2);
    wait_drain(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
